// File: rtl/capi_mmio_pkg.sv
// Shared definitions for the CAPI MMIO read-response path.
//   mmio_state_t : response collector states
//   MMIO_DW      : MMIO data width
//   MMIO_AD_W    : MMIO word-address width
//   odd_par64    : odd parity over a 64-bit word
//   sw_steer     : single-word replication of a 64-bit read word
// Bit 63 of a [63:0] vector corresponds to PSL big-endian bit 0.
package capi_mmio_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mmio_state_t;

  localparam int MMIO_DW   = 64;
  localparam int MMIO_AD_W = 24;

  // Odd parity: the parity bit makes the total count of ones odd.
  function automatic logic odd_par64(input logic [MMIO_DW-1:0] d);
    return ~^d;
  endfunction

  // ad23=0 addresses the low word (PSL bits [32:63]), ad23=1 the high
  // word (PSL bits [0:31]); the addressed word is copied into both halves.
  function automatic logic [MMIO_DW-1:0] sw_steer(input logic [MMIO_DW-1:0] d,
                                                  input logic dw,
                                                  input logic ad23);
    if (dw)
      return d;
    else if (ad23)
      return {d[63:32], d[63:32]};
    else
      return {d[31:0], d[31:0]};
  endfunction

endpackage

// File: rtl/capi_mmio_pri_sel.sv
// Lowest-index priority select over N_SRC slave response channels.
//   ack      in  N_SRC       per-channel response pulse
//   data     in  64*N_SRC    per-channel data, channel i at [64*i +: 64]
//   hit      out 1           any channel asserted
//   multi    out 1           more than one channel asserted
//   sel_data out 64          data of the lowest-index asserted channel
module capi_mmio_pri_sel
  import capi_mmio_pkg::*;
#(
  parameter int N_SRC = 4
) (
  input  logic [N_SRC-1:0]         ack,
  input  logic [MMIO_DW*N_SRC-1:0] data,
  output logic                     hit,
  output logic                     multi,
  output logic [MMIO_DW-1:0]       sel_data
);

  always_comb begin
    sel_data = '0;
    // Walk downwards so the lowest asserted index is written last.
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (ack[i])
        sel_data = data[i*MMIO_DW +: MMIO_DW];
    end
  end

  assign hit = |ack;
  // Clearing the lowest set bit leaves something only if two or more were set.
  assign multi = |(ack & (ack - N_SRC'(1)));

endmodule

// File: rtl/capi_mmio_rd_resp.sv
// Registered MMIO response collector between PSL and N_SRC AFU slaves.
// Tracks one outstanding request, returns the lowest-index slave response
// (with optional single-word replication), forces a fixed response on
// timeout and flags protocol violations.
//   clk, reset_n          clock, async active-low reset
//   ha_mmval/rnw/dw/ad    PSL MMIO request
//   src_ack, src_data     slave response pulses and data
//   ah_mmack/data/datapar registered response to PSL
//   err_timeout/err_proto single-cycle error pulses
//
// state | meaning
// IDLE  | no request outstanding; slave acks are spurious
// WAIT  | request latched, waiting for a slave ack or timeout
module capi_mmio_rd_resp
  import capi_mmio_pkg::*;
#(
  parameter int                 N_SRC    = 4,
  parameter int                 TO_W     = 8,
  parameter int                 TIMEOUT  = 255,
  parameter logic [MMIO_DW-1:0] TO_DATA  = 64'hFFFF_FFFF_FFFF_FFFF,
  parameter bit                 SW_STEER = 1'b1
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     ha_mmval,
  input  logic                     ha_mmrnw,
  input  logic                     ha_mmdw,
  input  logic [0:MMIO_AD_W-1]     ha_mmad,
  input  logic [N_SRC-1:0]         src_ack,
  input  logic [MMIO_DW*N_SRC-1:0] src_data,
  output logic                     ah_mmack,
  output logic [MMIO_DW-1:0]       ah_mmdata,
  output logic                     ah_mmdatapar,
  output logic                     err_timeout,
  output logic                     err_proto
);

  localparam bit             TO_EN   = (TIMEOUT != 0);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT - 1);
  localparam logic [TO_W-1:0] CNT_MAX = {TO_W{1'b1}};

  mmio_state_t        state, state_nxt;
  logic [TO_W-1:0]    cnt, cnt_nxt;
  logic               lat_rnw, lat_dw, lat_ad23;
  logic               rnw_nxt, dw_nxt, ad23_nxt;
  logic               ack_nxt, par_nxt, to_nxt, proto_nxt;
  logic [MMIO_DW-1:0] data_nxt;

  logic               sel_hit, sel_multi;
  logic [MMIO_DW-1:0] sel_data;

  // Only the word-select bit of the address matters for the response.
  logic unused_ad;
  assign unused_ad = ^ha_mmad[0:MMIO_AD_W-2];

  capi_mmio_pri_sel #(.N_SRC(N_SRC)) u_pri_sel (
    .ack      (src_ack),
    .data     (src_data),
    .hit      (sel_hit),
    .multi    (sel_multi),
    .sel_data (sel_data)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      lat_rnw      <= 1'b0;
      lat_dw       <= 1'b0;
      lat_ad23     <= 1'b0;
      ah_mmack     <= 1'b0;
      ah_mmdata    <= '0;
      ah_mmdatapar <= 1'b1;
      err_timeout  <= 1'b0;
      err_proto    <= 1'b0;
    end else begin
      state        <= state_nxt;
      cnt          <= cnt_nxt;
      lat_rnw      <= rnw_nxt;
      lat_dw       <= dw_nxt;
      lat_ad23     <= ad23_nxt;
      ah_mmack     <= ack_nxt;
      ah_mmdata    <= data_nxt;
      ah_mmdatapar <= par_nxt;
      err_timeout  <= to_nxt;
      err_proto    <= proto_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rnw_nxt   = lat_rnw;
    dw_nxt    = lat_dw;
    ad23_nxt  = lat_ad23;
    ack_nxt   = 1'b0;
    data_nxt  = ah_mmdata;
    to_nxt    = 1'b0;
    proto_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (sel_hit)
          proto_nxt = 1'b1;
        if (ha_mmval) begin
          rnw_nxt   = ha_mmrnw;
          dw_nxt    = ha_mmdw;
          ad23_nxt  = ha_mmad[MMIO_AD_W-1];
          cnt_nxt   = '0;
          state_nxt = WAIT;
        end
      end
      WAIT: begin
        // A second request while one is outstanding is dropped.
        if (ha_mmval)
          proto_nxt = 1'b1;
        if (sel_hit) begin
          ack_nxt = 1'b1;
          if (!lat_rnw)
            data_nxt = '0;
          else if (SW_STEER)
            data_nxt = sw_steer(sel_data, lat_dw, lat_ad23);
          else
            data_nxt = sel_data;
          if (sel_multi)
            proto_nxt = 1'b1;
          state_nxt = IDLE;
        end else if (TO_EN && (cnt == TO_LAST)) begin
          ack_nxt   = 1'b1;
          data_nxt  = lat_rnw ? TO_DATA : '0;
          to_nxt    = 1'b1;
          state_nxt = IDLE;
        end else if (cnt != CNT_MAX) begin
          cnt_nxt = cnt + TO_W'(1);
        end
      end
      default: state_nxt = IDLE;
    endcase

    par_nxt = odd_par64(data_nxt);
  end

endmodule

// File: doc/capi_mmio_rd_resp.md
Name: capi_mmio_rd_resp

Overview:
Registered MMIO response collector between the PSL MMIO request interface and N_SRC AFU register slaves. It tracks one outstanding MMIO request and selects the responding slave's data. For single-word reads it replicates the addressed 32-bit word into both halves. It generates odd parity, answers stalled requests via a timeout with a fixed response, and flags protocol errors. It replaces the combinational single-word steering previously placed in front of the PSL response.

Parameters:
N_SRC, 4, number of slave response channels (1..16)
TO_W, 8, width of the timeout counter
TIMEOUT, 255, cycles in WAIT before a forced response; 0 disables the timeout
TO_DATA, 64'hFFFF_FFFF_FFFF_FFFF, read data returned on timeout
SW_STEER, 1, 1 = single-word replication enabled; 0 = data passed unmodified

Ports:
clk  in  1  clock
reset_n  in  1  asynchronous active-low reset
ha_mmval  in  1  MMIO request valid, single-cycle pulse
ha_mmrnw  in  1  1 = read, 0 = write
ha_mmdw  in  1  1 = doubleword, 0 = single word
ha_mmad  in  24  word address [0:23]; bit 23 selects the word for single-word accesses
src_ack  in  N_SRC  per-slave response pulse
src_data  in  64*N_SRC  per-slave read data; channel i at [64*i +: 64], big-endian [0:63] within each channel
ah_mmack  out  1  response pulse to PSL
ah_mmdata  out  64  response data [0:63]
ah_mmdatapar  out  1  odd parity over ah_mmdata
err_timeout  out  1  one-cycle pulse when the timeout fires
err_proto  out  1  one-cycle pulse on a protocol violation

Behaviour:
- Reset (reset_n=0, asynchronous): state=IDLE, counter=0, latched fields=0, ah_mmack=0, ah_mmdata=0, ah_mmdatapar=1, err_*=0.
- States: IDLE, WAIT.
- IDLE:
  - When ha_mmval=1, latch rnw, dw, and ad[23]; clear the counter; go to WAIT.
  - Any src_ack in IDLE is ignored. It pulses err_proto the next cycle.
- WAIT, per cycle:
  - If any src_ack=1:
    - Select the lowest-index asserted channel.
    - Drive ah_mmack=1 next cycle with the processed data; return to IDLE.
    - If more than one bit is set, pulse err_proto.
  - Else, if TIMEOUT≠0 and counter==TIMEOUT-1:
    - Drive ah_mmack=1 next cycle with TO_DATA (reads) or 0 (writes).
    - Pulse err_timeout; return to IDLE.
  - Else increment the counter. The counter saturates and never wraps.
  - If src_ack and the timeout condition coincide, src_ack wins and err_timeout is not pulsed.
  - ha_mmval=1 in WAIT is dropped (no new request is latched) and pulses err_proto.
- Latency: src_ack at cycle t → ah_mmack at t+1. The minimum request-to-ack is 2 cycles. A src_ack in the same cycle as ha_mmval (in IDLE) counts as spurious.
- Data processing (reads only; writes return 64'h0):
  - dw=1 or SW_STEER=0: data unchanged.
  - dw=0, ad23=0: out[0:31]=in[32:63], out[32:63]=in[32:63].
  - dw=0, ad23=1: out[0:31]=in[0:31], out[32:63]=in[0:31].
- Parity: ah_mmdatapar = ~^ah_mmdata. Registered together with the data.
- Outputs:
  - ah_mmack and err_* are single-cycle pulses.
  - ah_mmdata and ah_mmdatapar hold their last values between responses.
- Reset asserted mid-WAIT: the request is abandoned and no ack is issued after reset releases.

Decomposition:
- Shared package capi_mmio_pkg holds:
  - state enum (IDLE, WAIT)
  - MMIO_DW=64 and MMIO_AD_W=24
  - function odd_par64
  - function sw_steer(data, dw, ad23)
- One sub-module, capi_mmio_pri_sel: parametrised lowest-index priority select and data mux over N_SRC channels, with a multi-hit flag output.

Test Plan:
- DW read, ch2: mmval (rnw=1, dw=1, ad=0x000010); two cycles later src_ack=4'b0100 with data 0x0123456789ABCDEF → one cycle later ah_mmack=1, data 0x0123456789ABCDEF, par=1, no errors.
- SW read, both words, ch0 data 0x11112222_33334444:
  - ad23=0 → ah_mmdata 0x33334444_33334444.
  - ad23=1 → ah_mmdata 0x11112222_11112222.
  - Repeat with SW_STEER=0 → data unchanged.
- Timeout with TIMEOUT=4, read, no src_ack → ah_mmack on the 5th cycle after mmval, data 0xFFFFFFFFFFFFFFFF, par=1, err_timeout pulse; a src_ack arriving afterwards → err_proto only, no ack.
- Multi-ack: src_ack=4'b1010 with distinct data → ch1 data returned, err_proto=1 for one cycle.
- Overrun: second mmval during WAIT → err_proto; exactly one ah_mmack, for the first request only.
- Reset mid-WAIT: assert reset_n=0 between mmval and src_ack → outputs go to reset values immediately; after release, src_ack → err_proto, no ack.
